shmcp_4_prog_loader: RTL
========================

// Module: shmcp_4_prog_loader
// PURPOSE
//  Host-side program loader for the SHMCP_4 core. Accepts program bytes over a valid/ready
//  stream, buffers them, and drives the core's load/instr/state pins. Emits one load pulse
//  per byte, in order, then a settle gap, then holds state=1 (run) until halted.
// PARAMETERS
//  FIFO_DEPTH   4   input buffer entries (power of 2, >=2)
//  MAX_PROG     16  max program bytes the core accepts (4-bit PC)
//  LOAD_SPACING 1   cycles between successive load pulses (>=1; 1 = back-to-back)
//  GAP_CYCLES   1   idle cycles after final load before state rises (>=0)
// PORTS
//  clk        in   1  clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  in_data/in_last valid
//  in_ready   out  1  loader can accept a byte this cycle
//  in_data    in   8  program byte
//  in_last    in   1  marks the final program byte (checksum byte when LOADER_CKSUM_EN)
//  halt       in   1  leave RUN/ERR, return to IDLE
//  load       out  1  to core: write instr this cycle
//  instr      out  8  to core: instruction byte
//  state      out  1  to core: 0 = load mode, 1 = run
//  busy       out  1  FSM not in IDLE
//  err        out  1  overflow or checksum error, sticky until halt/rst
// BEHAVIOUR
//  Reset: load=0, instr=8'h00, state=0, busy=0, err=0, in_ready=0 while rst high; FIFO
//   flushed, counters cleared, FSM=IDLE. Reset mid-load or mid-run aborts immediately.
//  Handshake: byte transfers on rising edge with in_valid&in_ready. in_ready = !fifo_full
//   in IDLE/LOAD, else 0. No push when full, even with a simultaneous pop.
//  FSM: IDLE -> LOAD on first accepted byte. LOAD: pop one byte when FIFO non-empty and
//   spacing counter expired; register load=1, instr=byte for exactly one cycle; spacing
//   counter reloads to LOAD_SPACING-1. Issued-byte count increments per pop.
//   LOAD -> GAP when the byte tagged in_last has been issued; bytes after in_last are
//   refused (in_ready=0). LOAD -> ERR if count reaches MAX_PROG and that byte lacks
//   in_last. GAP: load=0, state=0 for GAP_CYCLES cycles -> RUN.
//   RUN: state=1 held, load=0. ERR: err=1, load=0, state=0, FIFO flushed.
//   RUN/ERR + halt -> IDLE next edge: state=0, err=0, count=0. halt ignored in IDLE;
//   in LOAD/GAP, halt aborts to IDLE and flushes FIFO.
//  Latency: byte accepted at edge k (FIFO empty, spacing expired) -> load=1/instr valid
//   from edge k+1 for one cycle.
//  Only in_last among the first MAX_PROG bytes qualifies; in_last on byte MAX_PROG -> GAP.
// CONFIGURATION
//  LOADER_CKSUM_EN defined: 8-bit running sum over issued bytes; the in_last byte is a
//   checksum, not issued to the core (no load pulse). Sum of all bytes incl. checksum
//   must be 8'h00 mod 256 -> GAP, else ERR. Checksum byte excluded from MAX_PROG count.
//  Not defined: no checksum; in_last byte is a program byte and is loaded.
// TESTING
//  1 Defaults; stream 0F,2A,41,0D,07,34,06 (last on 06), in_valid held -> seven 1-cycle
//    load pulses in that order on consecutive cycles, 1 idle cycle, then state=1 held.
//  2 LOAD_SPACING=3, 8 bytes streamed continuously -> loads 3 cycles apart, in_ready low
//    once 4 bytes buffered, no byte lost or duplicated.
//  3 17 bytes, none tagged last -> 16 load pulses, err=1 after the 16th, 17th refused,
//    state stays 0; halt -> err=0, IDLE.
//  4 rst asserted after third load of test-1 program -> outputs zero asynchronously;
//    reload full program -> normal RUN entry, no stale bytes.
//  5 RUN, pulse halt one cycle -> state=0 next edge, busy=0, in_ready=1.
//  6 LOADER_CKSUM_EN: 2A,41 + cksum 95 -> 2 loads, RUN; cksum 96 -> err=1, state=0.

Source files
------------

// File: rtl/shmcp_4_prog_loader_if.sv
// Program byte stream into the SHMCP_4 loader: valid/ready handshake with a
// final-byte marker. The master is the host side and the slave is the loader.
interface shmcp_4_prog_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface : shmcp_4_prog_loader_if

// File: rtl/shmcp_4_prog_loader.sv
// Host-side program loader for the SHMCP_4 core.
// Buffers program bytes from a valid/ready stream in a small FIFO. It issues
// one load pulse per byte, in order, at the configured spacing. After the final
// byte it waits for a settle gap and then holds state=1 (run) until halt.
// Optional feature macro: LOADER_CKSUM_EN. When it is defined, the in_last byte
// is a checksum. It is not loaded into the core. The 8-bit sum of every byte,
// including the checksum, must be 8'h00, or the loader goes to the error state.
module shmcp_4_prog_loader #(
  parameter int FIFO_DEPTH   = 4,   // power of 2, >= 2
  parameter int MAX_PROG     = 16,  // 4-bit PC on the core
  parameter int LOAD_SPACING = 1,   // >= 1, 1 = back-to-back loads
  parameter int GAP_CYCLES   = 1    // idle cycles after the final load
) (
  input  logic                        clk,
  input  logic                        rst,
  shmcp_4_prog_loader_if.slave        in_if,
  input  logic                        halt,
  output logic                        load,
  output logic [7:0]                  instr,
  output logic                        state,
  output logic                        busy,
  output logic                        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;                    // pointer with wrap bit
  localparam int CW = $clog2(MAX_PROG + 2);      // holds MAX_PROG + 1
  localparam int SW = $clog2(LOAD_SPACING + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  // The checksum byte does not count toward the program limit, so the
  // checksum build may accept one extra byte.
`ifdef LOADER_CKSUM_EN
  localparam int ACC_MAX = MAX_PROG + 1;
`else
  localparam int ACC_MAX = MAX_PROG;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_RUN,
    S_ERR
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] space_q, space_d;      // cycles until the next pop may occur
  logic [CW-1:0] cnt_q, cnt_d;          // program bytes issued to the core
  logic [CW-1:0] acc_q, acc_d;          // bytes accepted from the stream
  logic          last_seen_q, last_seen_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          load_q, load_d;
  logic [7:0]    instr_q, instr_d;
  logic          state_q, state_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
`ifdef LOADER_CKSUM_EN
  logic [7:0]    sum_q, sum_d;          // running sum of the issued bytes
`endif

  // FIFO storage: {last, data} per entry.
  logic [8:0]    mem [FIFO_DEPTH];

  logic          fifo_full;
  logic          fifo_empty;
  logic          in_ready_c;
  logic          push;
  logic [7:0]    head_data;
  logic          head_last;

  // FIFO status, head entry and stream handshake.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_data  = mem[rd_ptr_q[AW-1:0]][7:0];
    head_last  = mem[rd_ptr_q[AW-1:0]][8];
    // Once the final byte is in, or the program limit is reached, further
    // bytes belong to no program and are refused at the port.
    in_ready_c = !rst && !fifo_full &&
                 ((fsm_q == S_IDLE) ||
                  ((fsm_q == S_LOAD) && !last_seen_q &&
                   (acc_q != CW'(ACC_MAX))));
    push       = in_if.in_valid && in_ready_c;
  end

  assign in_if.in_ready = in_ready_c;

  // Next-state, FIFO pointers, counters and registered core outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case. If any path leaves a
    // variable unassigned, synthesis infers a latch.
    fsm_d       = fsm_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q;
    space_d     = (space_q != '0) ? space_q - SW'(1) : space_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q + CW'(push);
    last_seen_d = last_seen_q | (push & in_if.in_last);
    gap_d       = gap_q;
    load_d      = 1'b0;
    instr_d     = 8'h00;
`ifdef LOADER_CKSUM_EN
    sum_d       = sum_q;
`endif

    case (fsm_q)
      S_IDLE: begin
        // halt is ignored here. The first accepted byte starts a load.
        if (push) fsm_d = S_LOAD;
      end

      S_LOAD: begin
        if (halt) begin
          fsm_d = S_IDLE;
        end else if (!fifo_empty && (space_q == '0)) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          space_d  = SW'(LOAD_SPACING - 1);
`ifdef LOADER_CKSUM_EN
          if (head_last) begin
            // The checksum byte only closes the program. It is never loaded.
            if (8'(sum_q + head_data) == 8'h00) fsm_d = S_GAP;
            else                                fsm_d = S_ERR;
          end else if (cnt_q == CW'(MAX_PROG)) begin
            // The program is already full and this byte is not the checksum.
            fsm_d = S_ERR;
          end else begin
            load_d  = 1'b1;
            instr_d = head_data;
            cnt_d   = cnt_q + CW'(1);
            sum_d   = sum_q + head_data;
          end
`else
          load_d  = 1'b1;
          instr_d = head_data;
          cnt_d   = cnt_q + CW'(1);
          if (head_last)                    fsm_d = S_GAP;
          else if (cnt_d == CW'(MAX_PROG))  fsm_d = S_ERR;
`endif
        end
      end

      S_GAP: begin
        // The cycle in which GAP is entered carries the last load pulse.
        // gap_q then counts the idle cycles that follow it.
        if (halt)                            fsm_d = S_IDLE;
        else if (gap_q == GW'(GAP_CYCLES))   fsm_d = S_RUN;
        else                                 gap_d = gap_q + GW'(1);
      end

      S_RUN: begin
        if (halt) fsm_d = S_IDLE;
      end

      S_ERR: begin
        if (halt) fsm_d = S_IDLE;
      end

      default: fsm_d = S_IDLE;
    endcase

    // An abort, an error or a return to idle discards any buffered bytes.
    if ((fsm_d == S_ERR) || ((fsm_d == S_IDLE) && (fsm_q != S_IDLE))) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // Every new program starts from clean counters.
    if (fsm_d == S_IDLE) begin
      cnt_d       = '0;
      acc_d       = '0;
      last_seen_d = 1'b0;
      space_d     = '0;
      gap_d       = '0;
`ifdef LOADER_CKSUM_EN
      sum_d       = 8'h00;
`endif
    end

    state_d = (fsm_d == S_RUN);
    busy_d  = (fsm_d != S_IDLE);
    err_d   = (fsm_d == S_ERR);
  end

  // State, pointers, counters and output registers. Reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      space_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      last_seen_q <= 1'b0;
      gap_q       <= '0;
      load_q      <= 1'b0;
      instr_q     <= 8'h00;
      state_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples the values from before the edge, so the order of these
      // statements does not matter.
      fsm_q       <= fsm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      space_q     <= space_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      last_seen_q <= last_seen_d;
      gap_q       <= gap_d;
      load_q      <= load_d;
      instr_q     <= instr_d;
      state_q     <= state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef LOADER_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // FIFO write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Validity comes only from the
    // pointers, which are reset and flushed, so stale contents are never read.
    if (push) mem[wr_ptr_q[AW-1:0]] <= {in_if.in_last, in_if.in_data};
  end

  assign load  = load_q;
  assign instr = instr_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule : shmcp_4_prog_loader
